stft_sweep_ctrl: RTL and testbench

//  Sequencer for the sliding-DFT SPU. For each accepted sample difference x[n]-x[n-N] it sweeps all
//  FFT_SIZE bins: drives Xk-RAM/twiddle-ROM read addresses, delay-aligns the SPU control inputs to the

---
 rtl/stft_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_stft_sweep_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stft_sweep_ctrl.sv
// Sweep sequencer for the sliding-DFT SPU: accepts one sample difference, reads every bin,
// aligns SPU controls to the memory read latency and closes the frame once all write-backs return.
module stft_sweep_ctrl #(
  parameter  int WORD_WIDTH  = 16,
  parameter  int FFT_SIZE    = 512,
  parameter  int RD_LATENCY  = 1,
  parameter  int SPU_LATENCY = 3,
  parameter  int DISP_DECIM  = 8,
  localparam int IDX_W       = $clog2(FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_sample_valid,
  input  logic [WORD_WIDTH-1:0] i_sample_diff,
  output logic                  o_sample_ready,
  output logic                  o_rd_en,
  output logic [IDX_W-1:0]      o_rd_idx,
  output logic [WORD_WIDTH-1:0] o_spu_sample_diff,
  output logic                  o_spu_wr_en,
  output logic                  o_spu_disp_wr_en,
  output logic [IDX_W-1:0]      o_spu_idx,
  input  logic                  i_wb_valid,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_overrun
);

  localparam int FLUSH_CYCLES = SPU_LATENCY + RD_LATENCY;
  localparam int FLUSH_W      = $clog2(FLUSH_CYCLES + 1);
  localparam int DECIM_W      = (DISP_DECIM > 1) ? $clog2(DISP_DECIM) : 1;

  localparam logic [IDX_W-1:0]   K_LAST     = IDX_W'(FFT_SIZE - 1);
  localparam logic [IDX_W:0]     WB_FULL    = (IDX_W + 1)'(FFT_SIZE);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DISP_DECIM - 1);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     k;
  logic [IDX_W:0]       wb_cnt;
  logic [IDX_W:0]       wb_cnt_next;
  logic [DECIM_W-1:0]   decim_cnt;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 disp_tag;
  logic                 accept;
  logic                 wb_count_en;

  logic [RD_LATENCY-1:0] pipe_en;
  logic [RD_LATENCY-1:0] pipe_disp;
  logic [IDX_W-1:0]      pipe_idx [RD_LATENCY];

  assign o_sample_ready = (state == ST_IDLE);
  assign accept         = i_sample_valid && o_sample_ready;
  assign o_overrun      = i_sample_valid && !o_sample_ready;
  assign o_busy         = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign o_rd_idx       = k;

  // Write-backs are counted only inside a frame and saturate, so a stray strobe cannot wrap the count.
  assign wb_count_en  = i_wb_valid && o_busy && (wb_cnt != WB_FULL);
  assign wb_cnt_next  = wb_cnt + (IDX_W + 1)'(wb_count_en);
  assign o_frame_done = (state == ST_DRAIN) && (wb_cnt_next == WB_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_FLUSH;
      k                 <= '0;
      wb_cnt            <= '0;
      decim_cnt         <= '0;
      flush_cnt         <= '0;
      disp_tag          <= 1'b0;
      o_rd_en           <= 1'b0;
      o_spu_sample_diff <= '0;
    end else begin
      case (state)
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        ST_IDLE: begin
          if (accept) begin
            o_spu_sample_diff <= i_sample_diff;
            disp_tag          <= (decim_cnt == '0);
            decim_cnt         <= (decim_cnt == DECIM_LAST) ? '0 : decim_cnt + DECIM_W'(1);
            k                 <= '0;
            wb_cnt            <= '0;
            o_rd_en           <= 1'b1;
            state             <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          wb_cnt <= wb_cnt_next;
          if (k == K_LAST) begin
            k       <= '0;
            o_rd_en <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            k <= k + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          wb_cnt <= wb_cnt_next;
          if (o_frame_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

  // Delay line matching the Xk RAM / twiddle ROM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_en   <= '0;
      pipe_disp <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_disp[i] <= pipe_disp[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
      end
      pipe_en[0]   <= o_rd_en;
      pipe_disp[0] <= disp_tag && o_rd_en;
      pipe_idx[0]  <= k;
    end
  end

  assign o_spu_wr_en      = pipe_en[RD_LATENCY-1];
  assign o_spu_disp_wr_en = pipe_disp[RD_LATENCY-1];
  assign o_spu_idx        = pipe_idx[RD_LATENCY-1];

endmodule

// File: tb/tb_stft_sweep_ctrl.sv
// Directed bench for stft_sweep_ctrl with an 8-bin sweep and the SPU modelled as a 3-stage delay.
module tb_stft_sweep_ctrl;

  localparam int WW = 16;
  localparam int FS = 8;
  localparam int RL = 1;
  localparam int SL = 3;
  localparam int DD = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [WW-1:0] sample_diff = '0;
  logic          sample_ready;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic [WW-1:0] spu_diff;
  logic          spu_wr_en;
  logic          spu_disp_wr_en;
  logic [IW-1:0] spu_idx;
  logic          wb_valid;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  logic [SL-1:0] wb_pipe = '0;
  logic          drop_en = 1'b0;
  logic [IW-1:0] drop_idx = '0;
  logic [28:0]   all_outs;

  int checks = 0;
  int failures = 0;

  stft_sweep_ctrl #(
    .WORD_WIDTH (WW),
    .FFT_SIZE   (FS),
    .RD_LATENCY (RL),
    .SPU_LATENCY(SL),
    .DISP_DECIM (DD)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_sample_valid   (sample_valid),
    .i_sample_diff    (sample_diff),
    .o_sample_ready   (sample_ready),
    .o_rd_en          (rd_en),
    .o_rd_idx         (rd_idx),
    .o_spu_sample_diff(spu_diff),
    .o_spu_wr_en      (spu_wr_en),
    .o_spu_disp_wr_en (spu_disp_wr_en),
    .o_spu_idx        (spu_idx),
    .i_wb_valid       (wb_valid),
    .o_busy           (busy),
    .o_frame_done     (frame_done),
    .o_overrun        (overrun)
  );

  always #5 clk = ~clk;

  // SPU stand-in: write-back strobe is the aligned wr_en delayed SPU_LATENCY cycles, optionally losing one bin.
  always @(posedge clk) begin
    wb_pipe <= {wb_pipe[SL-2:0], spu_wr_en && !(drop_en && (spu_idx == drop_idx))};
  end
  assign wb_valid = wb_pipe[SL-1];

  assign all_outs = {sample_ready, rd_en, rd_idx, spu_diff, spu_wr_en, spu_disp_wr_en,
                     spu_idx, busy, frame_done, overrun};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycle;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (4) wait_cycle();
  endtask

  // Waits (bounded) for ready, offers one sample for exactly one edge, returns 2 ns after that edge.
  task automatic accept(input logic [WW-1:0] diff, output int waited);
    waited = 0;
    while (!sample_ready && waited < 40) begin
      wait_cycle();
      waited++;
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL accept_timeout ready=%b exp=1 after %0d cycles", sample_ready, waited);
    end
    sample_valid = 1'b1;
    sample_diff  = diff;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", all_outs);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) wait_cycle();
      checks++;
      if (sample_ready !== (i == 4)) begin
        failures++;
        $display("[TB] FAIL flush_ready cycle=%0d got=%b exp=%b", i, sample_ready, (i == 4));
      end
      checks++;
      if (all_outs[27:0] !== '0) begin
        failures++;
        $display("[TB] FAIL flush_outputs cycle=%0d got=%h exp=0", i, all_outs[27:0]);
      end
    end
  endtask

  task automatic test_single_sweep;
    int   waited;
    logic e_rd, e_wr, e_fd, e_rdy, e_busy;
    accept(16'h0123, waited);
    for (int t = 1; t <= 14; t++) begin
      if (t > 1) wait_cycle();
      e_rd   = (t >= 1) && (t <= 8);
      e_wr   = (t >= 2) && (t <= 9);
      e_fd   = (t == 12);
      e_rdy  = (t >= 13);
      e_busy = (t <= 12);
      checks++;
      if ({rd_en, spu_wr_en, spu_disp_wr_en, frame_done, sample_ready, busy, overrun} !==
          {e_rd, e_wr, e_wr, e_fd, e_rdy, e_busy, 1'b0}) begin
        failures++;
        $display("[TB] FAIL sweep_ctrl cycle=%0d got=%b exp=%b", t,
                 {rd_en, spu_wr_en, spu_disp_wr_en, frame_done, sample_ready, busy, overrun},
                 {e_rd, e_wr, e_wr, e_fd, e_rdy, e_busy, 1'b0});
      end
      if (e_rd) begin
        checks++;
        if (rd_idx !== IW'(t - 1)) begin
          failures++;
          $display("[TB] FAIL sweep_rd_idx cycle=%0d got=%0d exp=%0d", t, rd_idx, t - 1);
        end
      end
      if (e_wr) begin
        checks++;
        if (spu_idx !== IW'(t - 2)) begin
          failures++;
          $display("[TB] FAIL sweep_spu_idx cycle=%0d got=%0d exp=%0d", t, spu_idx, t - 2);
        end
      end
      checks++;
      if (spu_diff !== 16'h0123) begin
        failures++;
        $display("[TB] FAIL sweep_diff cycle=%0d got=%h exp=0123", t, spu_diff);
      end
    end
  endtask

  task automatic test_back_to_back;
    int waited, wr_cnt, disp_cnt, fd_t;
    logic [WW-1:0] diff;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      diff = 16'h1000 + WW'(s);
      accept(diff, waited);
      if (s > 0) begin
        checks++;
        if (waited != 0) begin
          failures++;
          $display("[TB] FAIL b2b_rate sweep=%0d waited=%0d exp=0", s, waited);
        end
      end
      wr_cnt = 0;
      disp_cnt = 0;
      fd_t = 0;
      for (int t = 1; t <= 12; t++) begin
        if (t > 1) wait_cycle();
        if (spu_wr_en) begin
          checks++;
          if (spu_idx !== IW'(wr_cnt)) begin
            failures++;
            $display("[TB] FAIL b2b_idx sweep=%0d got=%0d exp=%0d", s, spu_idx, wr_cnt);
          end
          wr_cnt++;
        end
        if (spu_disp_wr_en) disp_cnt++;
        checks++;
        if ((spu_disp_wr_en && !spu_wr_en) !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_disp_alone sweep=%0d cycle=%0d got=1 exp=0", s, t);
        end
        if (frame_done) fd_t = t;
      end
      checks++;
      if (wr_cnt != FS) begin
        failures++;
        $display("[TB] FAIL b2b_wr_count sweep=%0d got=%0d exp=%0d", s, wr_cnt, FS);
      end
      checks++;
      if (disp_cnt != ((s % 2 == 0) ? FS : 0)) begin
        failures++;
        $display("[TB] FAIL b2b_disp_count sweep=%0d got=%0d exp=%0d", s, disp_cnt,
                 (s % 2 == 0) ? FS : 0);
      end
      checks++;
      if (fd_t != 12) begin
        failures++;
        $display("[TB] FAIL b2b_frame_done sweep=%0d got_cycle=%0d exp=12", s, fd_t);
      end
      checks++;
      if (spu_diff !== diff) begin
        failures++;
        $display("[TB] FAIL b2b_diff sweep=%0d got=%h exp=%h", s, spu_diff, diff);
      end
      wait_cycle();
    end
  endtask

  task automatic test_overrun;
    int waited, n, fd;
    accept(16'h0AAA, waited);
    sample_valid = 1'b1;
    sample_diff  = 16'h0555;
    for (int t = 1; t <= 5; t++) begin
      if (t > 1) wait_cycle();
      #1;
      checks++;
      if ({overrun, busy, sample_ready} !== 3'b110) begin
        failures++;
        $display("[TB] FAIL overrun_pulse cycle=%0d got=%b exp=110", t, {overrun, busy, sample_ready});
      end
      checks++;
      if (spu_diff !== 16'h0AAA) begin
        failures++;
        $display("[TB] FAIL overrun_diff cycle=%0d got=%h exp=0aaa", t, spu_diff);
      end
    end
    sample_valid = 1'b0;
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_clear got=%b exp=0", overrun);
    end
    n = 0;
    fd = 0;
    while (!sample_ready && n < 30) begin
      wait_cycle();
      n++;
      if (frame_done) fd++;
    end
    checks++;
    if ({sample_ready, fd[1:0]} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL overrun_frame ready=%b frame_done_pulses=%0d exp ready=1 pulses=1",
               sample_ready, fd);
    end
    checks++;
    if (spu_diff !== 16'h0AAA) begin
      failures++;
      $display("[TB] FAIL overrun_diff_end got=%h exp=0aaa", spu_diff);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int waited, n;
    accept(16'h0BBB, waited);
    for (int t = 2; t <= 5; t++) wait_cycle();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%h exp=0", all_outs);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) wait_cycle();
      checks++;
      if ({sample_ready, frame_done, busy, spu_wr_en} !== {(i == 4), 3'b000}) begin
        failures++;
        $display("[TB] FAIL midreset_flush cycle=%0d got=%b exp=%b", i,
                 {sample_ready, frame_done, busy, spu_wr_en}, {(i == 4), 3'b000});
      end
      if (i == 1) begin
        sample_valid = 1'b1;
        #1;
        checks++;
        if ({overrun, sample_ready} !== 2'b10) begin
          failures++;
          $display("[TB] FAIL flush_overrun got=%b exp=10", {overrun, sample_ready});
        end
        sample_valid = 1'b0;
      end
    end
    accept(16'h0CCC, waited);
    wait_cycle();
    checks++;
    if ({spu_wr_en, spu_disp_wr_en, spu_idx} !== {2'b11, 3'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_decim got=%b exp=11000", {spu_wr_en, spu_disp_wr_en, spu_idx});
    end
    n = 0;
    while (!sample_ready && n < 30) begin
      wait_cycle();
      n++;
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_recover ready=%b exp=1", sample_ready);
    end
  endtask

  task automatic test_dropped_wb;
    int waited, fd;
    drop_en  = 1'b1;
    drop_idx = 3'd3;
    accept(16'h0DDD, waited);
    fd = 0;
    for (int t = 1; t <= 25; t++) begin
      if (t > 1) wait_cycle();
      if (frame_done) fd++;
    end
    checks++;
    if (fd != 0) begin
      failures++;
      $display("[TB] FAIL drop_frame_done got=%0d exp=0", fd);
    end
    checks++;
    if ({busy, sample_ready, rd_en} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL drop_hang got=%b exp=100", {busy, sample_ready, rd_en});
    end
    drop_en = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_back_to_back();
    test_overrun();
    test_reset_mid_sweep();
    test_dropped_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
